// File: rtl/cache_control.sv
// Direct-mapped write-back cache controller: per-set valid/dirty/tag, IDLE/COMPARE/WRITEBACK/ALLOCATE FSM.
// Optional hit/miss statistics are built when CACHE_STATS_EN is defined.
module cache_control #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [31:0]                 mem_address,
  input  logic [31:0]                 mem_wdata,
  input  logic [3:0]                  mem_byte_enable,
  output logic [31:0]                 mem_rdata,
  output logic                        mem_resp,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [31:0]                 pmem_address,
  output logic [(8<<S_OFFSET)-1:0]    pmem_wdata,
  input  logic [(8<<S_OFFSET)-1:0]    pmem_rdata,
  input  logic                        pmem_resp,
  output logic                        da_read,
  output logic [S_INDEX-1:0]          da_rindex,
  output logic [S_INDEX-1:0]          da_windex,
  output logic [(1<<S_OFFSET)-1:0]    da_write_en,
  output logic [(8<<S_OFFSET)-1:0]    da_datain,
  input  logic [(8<<S_OFFSET)-1:0]    da_dataout,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);
  localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
  localparam int SETS   = 1 << S_INDEX;
  localparam int LINE_B = 1 << S_OFFSET;
  localparam int WORDS  = LINE_B / 4;
  localparam int WORD_W = S_OFFSET - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t state;

  logic [SETS-1:0]    valid, dirty;
  logic [TAG_W-1:0]   tags [SETS];
  logic [TAG_W-1:0]   tag_q;
  logic [S_INDEX-1:0] idx_q;
  logic [WORD_W-1:0]  word_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               wr_q;
  logic               req, hit;

  logic unused;
  assign unused = &{1'b0, mem_address[1:0]};

  assign req = mem_read | mem_write;
  assign hit = valid[idx_q] && (tags[idx_q] == tag_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE:      if (req) state <= COMPARE;
        COMPARE: begin
          if (hit) begin
            if (wr_q) dirty[idx_q] <= 1'b1;
            state <= IDLE;
          end else if (dirty[idx_q]) begin
            state <= WRITEBACK;
          end else begin
            state <= ALLOCATE;
          end
        end
        WRITEBACK: if (pmem_resp) begin
          dirty[idx_q] <= 1'b0;
          state        <= ALLOCATE;
        end
        ALLOCATE:  if (pmem_resp) begin
          valid[idx_q] <= 1'b1;
          dirty[idx_q] <= 1'b0;
          state        <= COMPARE;
        end
        default:   state <= IDLE;
      endcase
    end
  end

  // Request latch and tag store carry no reset; tags are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && req) begin
      tag_q   <= mem_address[31 -: TAG_W];
      idx_q   <= mem_address[S_OFFSET +: S_INDEX];
      word_q  <= mem_address[S_OFFSET-1:2];
      wdata_q <= mem_wdata;
      be_q    <= mem_byte_enable;
      wr_q    <= mem_write;
    end
    if (rst_n && state == ALLOCATE && pmem_resp) tags[idx_q] <= tag_q;
  end

  assign pmem_wdata = da_dataout;
  assign mem_rdata  = da_dataout[32*word_q +: 32];

  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag_q, idx_q, {S_OFFSET{1'b0}}};
    da_read      = 1'b0;
    da_rindex    = idx_q;
    da_windex    = idx_q;
    da_write_en  = '0;
    da_datain    = {WORDS{wdata_q}};
    case (state)
      IDLE: begin
        da_rindex = mem_address[S_OFFSET +: S_INDEX];
        da_read   = rst_n & req;
      end
      COMPARE: if (hit) begin
        mem_resp = 1'b1;
        if (wr_q) da_write_en = LINE_B'(be_q) << {word_q, 2'b00};
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[idx_q], idx_q, {S_OFFSET{1'b0}}};
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          da_write_en = '1;
          da_datain   = pmem_rdata;
          da_read     = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  // filled marks the COMPARE that follows a fill so it is not counted as a hit.
  logic filled;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      filled     <= 1'b0;
    end else begin
      if (state == IDLE && req) filled <= 1'b0;
      if (state == ALLOCATE && pmem_resp) filled <= 1'b1;
      if (state == COMPARE) begin
        if (hit && !filled && hit_count != '1) hit_count <= hit_count + 32'd1;
        if (!hit && miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: behavioural data array with write forwarding and a line memory.
module tb_cache_control;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]  mem_address = '0, mem_wdata = '0;
  logic [3:0]   mem_byte_enable = '0;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic         da_read;
  logic [2:0]   da_rindex, da_windex;
  logic [31:0]  da_write_en;
  logic [255:0] da_datain;
  logic [255:0] da_dataout = '0;
  logic [31:0]  hit_count, miss_count;

  int errors = 0;
  int checks = 0;

  cache_control dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .da_read(da_read), .da_rindex(da_rindex), .da_windex(da_windex),
    .da_write_en(da_write_en), .da_datain(da_datain), .da_dataout(da_dataout),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // data array model: per-byte write, read registered, same-cycle write forwarded
  logic [255:0] darr [8];
  initial for (int i = 0; i < 8; i++) darr[i] = '0;

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                         input logic [31:0] we);
    logic [255:0] r = old;
    for (int b = 0; b < 32; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (|da_write_en) darr[da_windex] <= merge(darr[da_windex], da_datain, da_write_en);
    if (da_read)
      da_dataout <= (|da_write_en && da_windex == da_rindex)
                    ? merge(darr[da_windex], da_datain, da_write_en) : darr[da_rindex];
  end

  // line memory with a two-cycle response and a log of transfers
  logic [255:0] pmem [int unsigned];
  bit           log_wr [$];
  logic [31:0]  log_a  [$];
  logic [255:0] log_d  [$];
  bit           auto_resp = 1'b1;
  bit           man_resp = 1'b0;
  int           cnt = 0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (pmem.exists(a)) return pmem[a];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = a + w;
    return l;
  endfunction

  always @(negedge clk) begin
    if (!auto_resp) begin
      pmem_resp = man_resp;
      cnt = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pmem_read || pmem_write) begin
      cnt++;
      if (cnt == 2) begin
        pmem_resp = 1'b1;
        log_wr.push_back(pmem_write);
        log_a.push_back(pmem_address);
        log_d.push_back(pmem_wdata);
        if (pmem_write) pmem[pmem_address] = pmem_wdata;
        else pmem_rdata = line_of(pmem_address);
      end
    end else begin
      cnt = 0;
    end
  end

  always @(negedge clk) chk("pmem_excl", {63'd0, pmem_read & pmem_write}, 64'd0);

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int cyc,
                        output logic [31:0] we);
    @(negedge clk);
    mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 60);
    chk("resp_seen", {63'd0, mem_resp}, 64'd1);
    rd = mem_rdata;
    we = da_write_en;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 32'hFFFF_FFFF; mem_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("resp_pulse", {63'd0, mem_resp}, 64'd0);
  endtask

  logic [31:0]  rd, we;
  int           cyc, base, n;
  logic [255:0] exp_line;

  initial begin
    for (int w = 0; w < 8; w++) exp_line[32*w +: 32] = 32'h0000_1000 + w;
    exp_line[95:64] = 32'hDEAD_BEEF;
    pmem[32'h40] = exp_line;

    repeat (3) @(negedge clk);
    chk("rst_resp",  {63'd0, mem_resp}, 64'd0);
    chk("rst_pread", {63'd0, pmem_read}, 64'd0);
    chk("rst_pwr",   {63'd0, pmem_write}, 64'd0);
    chk("rst_daread", {63'd0, da_read}, 64'd0);
    chk("rst_dawe",  {32'd0, da_write_en}, 64'd0);
    chk("rst_hits",  {32'd0, hit_count}, 64'd0);
    chk("rst_miss",  {32'd0, miss_count}, 64'd0);
    rst_n = 1'b1;

    // cold miss fill of set 2
    access(1'b0, 32'h40, 0, 0, rd, cyc, we);
    chk("fill_rd", {32'd0, rd}, 64'h0000_1000);
    chk("fill_log_n", log_a.size(), 1);
    chk("fill_addr", {32'd0, log_a[0]}, 64'h40);
    chk("fill_is_rd", {63'd0, log_wr[0]}, 64'd0);
    chk("fill_lat_gt1", {63'd0, cyc > 1}, 64'd1);

    access(1'b0, 32'h48, 0, 0, rd, cyc, we);
    chk("hit_rd", {32'd0, rd}, 64'hDEAD_BEEF);
    chk("hit_lat", cyc, 1);

    access(1'b1, 32'h44, 32'h1122_3344, 4'b0011, rd, cyc, we);
    chk("wr_lat", cyc, 1);
    chk("wr_we", {32'd0, we}, 64'h30);

    access(1'b0, 32'h44, 0, 0, rd, cyc, we);
    chk("merge_rd", {32'd0, rd}, 64'h0000_3344);
    chk("rd_we_zero", {32'd0, we}, 64'd0);

    // conflict miss on dirty set 2: writeback then fill
    base = log_a.size();
    exp_line[63:32] = 32'h0000_3344;
    access(1'b0, 32'h1000_0040, 0, 0, rd, cyc, we);
    chk("evict_rd", {32'd0, rd}, 64'h1000_0040);
    chk("evict_log_n", log_a.size() - base, 2);
    chk("wb_is_wr", {63'd0, log_wr[base]}, 64'd1);
    chk("wb_addr", {32'd0, log_a[base]}, 64'h40);
    for (int w = 0; w < 8; w++)
      chk($sformatf("wb_w%0d", w), {32'd0, log_d[base][32*w +: 32]}, {32'd0, exp_line[32*w +: 32]});
    chk("refill_is_rd", {63'd0, log_wr[base+1]}, 64'd0);
    chk("refill_addr", {32'd0, log_a[base+1]}, 64'h1000_0040);

`ifdef CACHE_STATS_EN
    chk("stat_hits", {32'd0, hit_count}, 64'd3);
    chk("stat_miss", {32'd0, miss_count}, 64'd2);
`else
    chk("stat_hits", {32'd0, hit_count}, 64'd0);
    chk("stat_miss", {32'd0, miss_count}, 64'd0);
`endif

    // clean conflict miss: fill only, written-back data comes back
    base = log_a.size();
    access(1'b0, 32'h44, 0, 0, rd, cyc, we);
    chk("clean_log_n", log_a.size() - base, 1);
    chk("clean_is_rd", {63'd0, log_wr[base]}, 64'd0);
    chk("clean_rd", {32'd0, rd}, 64'h0000_3344);

    // reset during ALLOCATE, late pmem_resp must be ignored
    auto_resp = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h1000_0060;
    n = 0;
    while (!pmem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("alloc_seen", {63'd0, pmem_read}, 64'd1);
    chk("alloc_addr", {32'd0, pmem_address}, 64'h1000_0060);
    rst_n = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("arst_pread", {63'd0, pmem_read}, 64'd0);
    chk("arst_resp", {63'd0, mem_resp}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 man_resp = 1'b1;
    @(negedge clk);
    #1;
    chk("late_resp_on", {63'd0, pmem_resp}, 64'd1);
    chk("late_dawe", {32'd0, da_write_en}, 64'd0);
    chk("late_pread", {63'd0, pmem_read}, 64'd0);
    chk("late_mresp", {63'd0, mem_resp}, 64'd0);
    @(posedge clk);
    #1 man_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_mresp", {63'd0, mem_resp}, 64'd0);
    auto_resp = 1'b1;

    // set 2 was valid before reset; it must miss now
    base = log_a.size();
    access(1'b0, 32'h44, 0, 0, rd, cyc, we);
    chk("post_rst_miss", log_a.size() - base, 1);
    chk("post_rst_addr", {32'd0, log_a[base]}, 64'h40);
    chk("post_rst_rd", {32'd0, rd}, 64'h0000_3344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 64'd1, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter S_INDEX, default 3, meaning set-index width (8 sets).
REQ-002 SHALL have parameter S_OFFSET, default 5, meaning line-offset width (32-byte line); tag width = 32-S_INDEX-S_OFFSET.
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
- mem_address  in  32  CPU byte address.
- mem_wdata  in  32  CPU store data.
- mem_byte_enable  in  4  CPU store byte lanes.
- mem_rdata  out  32  CPU load data.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read, pmem_write  out  1 each  line-memory strobes, held until pmem_resp.
- pmem_address  out  32  line address, low S_OFFSET bits zero.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  line-memory completion pulse.
- da_read  out  1  data-array read enable.
- da_rindex, da_windex  out  S_INDEX each  data-array read/write set.
- da_write_en  out  32  data-array per-byte write mask.
- da_datain  out  256  data-array write line.
- da_dataout  in  256  data-array read line, valid one cycle after da_read.
- hit_count, miss_count  out  32 each  statistics (REQ-021).

Function
REQ-004 SHALL hold per set a valid bit, dirty bit and tag register; direct-mapped.
REQ-005 SHALL implement states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-006 IDLE: on mem_read|mem_write, SHALL latch address/wdata/byte_enable/op, drive da_read=1 with da_rindex=index, go to COMPARE; otherwise stay in IDLE.
REQ-007 Both strobes high SHALL be treated as a write.
REQ-008 COMPARE hit (valid & tag match), read: mem_rdata = da_dataout word addr[4:2], mem_resp=1, go to IDLE; mem_resp occurs the cycle after the request is first sampled.
REQ-009 COMPARE hit, write: da_windex=index, da_write_en = byte_enable shifted to bytes 4*addr[4:2]..+3, da_datain = wdata replicated 8x, set dirty, mem_resp=1, go to IDLE.
REQ-010 COMPARE miss: dirty SHALL go to WRITEBACK, clean SHALL go to ALLOCATE; no mem_resp.
REQ-011 WRITEBACK: pmem_write=1, pmem_address={stored tag,index,0}, pmem_wdata=da_dataout (held, da_read=0); on pmem_resp, clear dirty and go to ALLOCATE.
REQ-012 ALLOCATE: pmem_read=1, pmem_address={request tag,index,0}; on pmem_resp, da_write_en=all ones, da_datain=pmem_rdata, da_windex=da_rindex=index, da_read=1, tag updated, valid=1, dirty=0, go to COMPARE (hit via data-array write forwarding).
REQ-013 da_write_en SHALL be zero in every cycle not named in REQ-009/REQ-012; pmem strobes SHALL never be high together.
REQ-014 mem_resp SHALL be exactly one cycle per request; mem_rdata is don't-care when mem_resp=0.
REQ-015 Miss-path request SHALL use the latched copy; CPU input changes after IDLE sampling SHALL be ignored.

Reset
REQ-016 rst_n=0 at a clk edge SHALL force IDLE, clear all valid and dirty bits, and drive mem_resp, pmem_read, pmem_write, da_read, da_write_en to 0 next cycle.
REQ-017 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transfer; a late pmem_resp SHALL be ignored.
REQ-018 Tags need not be reset; data-array contents are not touched by reset.
REQ-019 Statistics counters SHALL reset to 0.

Configuration
REQ-020 Macro CACHE_STATS_EN SHALL gate the statistics feature.
REQ-021 Defined: hit_count increments on each COMPARE hit completing a request (not the post-fill COMPARE), miss_count on each COMPARE miss; both saturate at 0xFFFFFFFF. Undefined: both outputs constant 0, no counter flops.

Verification
REQ-022 After reset, read 0x0000_0040 -> ALLOCATE, pmem_address=0x0000_0040, pmem_rdata word2=0xDEADBEEF; read 0x48 -> mem_rdata=0xDEADBEEF, mem_resp one cycle after request.
REQ-023 Write 0x0000_0044, wdata=0x11223344, byte_enable=4'b0011 on resident line -> da_write_en=0x00000030, dirty set, read back merges low 2 bytes.
REQ-024 Dirty set 2 at tag A, read 0x1000_0040 -> pmem_write at {A,2,0} with modified line, then pmem_read at 0x1000_0040, then mem_resp.
REQ-025 rst_n low during ALLOCATE with pmem_resp 3 cycles later -> IDLE, pmem_read=0, no data-array write, next read misses.
REQ-026 With CACHE_STATS_EN: 3 hits, 2 misses -> hit_count=3, miss_count=2; without -> both 0.
